// File: rtl/sm3_pad_param_if.sv
// ============================================================================
// sm3_pad_param_if : message-in / padded-word-out bus of the SM3 padder
// Revision         : 1.0
// ============================================================================
`default_nettype none

interface sm3_pad_param_if #(
   parameter int DW = 32
) ();
   logic [DW-1:0]   msg_inpt_d;
   logic [DW/8-1:0] msg_inpt_vld_byte;
   logic            msg_inpt_vld;
   logic            msg_inpt_lst;
   logic            msg_inpt_rdy;
   logic            pad_otpt_ena;
   logic [DW-1:0]   pad_otpt_d;
   logic            pad_otpt_vld;
   logic            pad_otpt_lst;

   modport master (
      output msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst, pad_otpt_ena,
      input  msg_inpt_rdy, pad_otpt_d, pad_otpt_vld, pad_otpt_lst
   );

   modport slave (
      input  msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst, pad_otpt_ena,
      output msg_inpt_rdy, pad_otpt_d, pad_otpt_vld, pad_otpt_lst
   );
endinterface

`default_nettype wire

// File: rtl/sm3_pad_param.sv
// ============================================================================
// sm3_pad_param : SM3 padder, DW-bit message words in, padded 512-bit blocks out
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sm3_pad_param #(
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   sm3_pad_param_if.slave  bus
);
   localparam int NB  = DW / 8;
   localparam int WPB = 512 / DW;
   localparam int LW  = 64 / DW;
   localparam int WIW = $clog2(WPB);
   localparam int KW  = $clog2(NB + 1);

   localparam logic [1:0] ST_MSG   = 2'd0;
   localparam logic [1:0] ST_PAD80 = 2'd1;
   localparam logic [1:0] ST_ZERO  = 2'd2;
   localparam logic [1:0] ST_LEN   = 2'd3;

   localparam logic [WIW-1:0] WI_LAST_ZERO = WIW'(WPB - LW - 1);
   localparam logic [WIW-1:0] WI_LAST      = WIW'(WPB - 1);

   logic [1:0]     state_q, state_d;
   logic [WIW-1:0] wi_q, wi_d;
   logic [60:0]    bytes_q, bytes_d;
   logic [DW-1:0]  dat_q, dat_d;
   logic           vld_q, vld_d;
   logic           lst_q, lst_d;

   logic           adv;
   logic           in_rdy;
   logic           in_fire;
   logic [1:0]     after_pad;
   logic [63:0]    len_bits;
   logic [DW-1:0]  len_word;
   logic [DW-1:0]  last_word;
   logic [KW-1:0]  k;
   logic           run;

   assign adv       = !vld_q || bus.pad_otpt_ena;
   // A stalled or departing final word blocks the next message for one cycle.
   assign in_rdy    = rst_n && (state_q == ST_MSG) && (!vld_q || (bus.pad_otpt_ena && !lst_q));
   assign in_fire   = bus.msg_inpt_vld && in_rdy;
   assign after_pad = (wi_q == WI_LAST_ZERO) ? ST_LEN : ST_ZERO;
   assign len_bits  = {bytes_q, 3'b000};

   generate
      if (DW == 64) begin : g_len64
         assign len_word = len_bits;
      end else begin : g_len32
         assign len_word = wi_q[0] ? len_bits[31:0] : len_bits[63:32];
      end
   endgenerate

   always_comb begin
      k   = '0;
      run = 1'b1;
      for (int i = 0; i < NB; i++) begin
         if (run && bus.msg_inpt_vld_byte[NB-1-i]) begin
            k = KW'(i + 1);
         end else begin
            run = 1'b0;
         end
      end
   end

   always_comb begin
      last_word = '0;
      for (int i = 0; i < NB; i++) begin
         if (i < int'(k)) begin
            last_word[DW-1-8*i -: 8] = bus.msg_inpt_d[DW-1-8*i -: 8];
         end else if (i == int'(k)) begin
            last_word[DW-1-8*i -: 8] = 8'h80;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      wi_d    = wi_q;
      bytes_d = bytes_q;
      dat_d   = dat_q;
      vld_d   = vld_q;
      lst_d   = lst_q;
      if (adv) begin
         vld_d = 1'b0;
         lst_d = 1'b0;
         case (state_q)
            ST_MSG: begin
               if (in_fire) begin
                  vld_d = 1'b1;
                  wi_d  = wi_q + WIW'(1);
                  if (!bus.msg_inpt_lst) begin
                     dat_d   = bus.msg_inpt_d;
                     bytes_d = bytes_q + 61'(NB);
                  end else begin
                     dat_d   = last_word;
                     bytes_d = bytes_q + 61'(k);
                     state_d = (k == KW'(NB)) ? ST_PAD80 : after_pad;
                  end
               end
            end
            ST_PAD80: begin
               dat_d   = {8'h80, {(DW-8){1'b0}}};
               vld_d   = 1'b1;
               wi_d    = wi_q + WIW'(1);
               state_d = after_pad;
            end
            ST_ZERO: begin
               dat_d = '0;
               vld_d = 1'b1;
               wi_d  = wi_q + WIW'(1);
               if (wi_q == WI_LAST_ZERO) begin
                  state_d = ST_LEN;
               end
            end
            ST_LEN: begin
               dat_d = len_word;
               vld_d = 1'b1;
               wi_d  = wi_q + WIW'(1);
               if (wi_q == WI_LAST) begin
                  lst_d   = 1'b1;
                  bytes_d = '0;
                  state_d = ST_MSG;
               end
            end
            default: state_d = ST_MSG;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_MSG;
         wi_q    <= '0;
         bytes_q <= '0;
         dat_q   <= '0;
         vld_q   <= 1'b0;
         lst_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wi_q    <= wi_d;
         bytes_q <= bytes_d;
         dat_q   <= dat_d;
         vld_q   <= vld_d;
         lst_q   <= lst_d;
      end
   end

   assign bus.msg_inpt_rdy = in_rdy;
   assign bus.pad_otpt_d   = dat_q;
   assign bus.pad_otpt_vld = vld_q;
   assign bus.pad_otpt_lst = lst_q;

endmodule

`default_nettype wire

// File: tb/tb_sm3_pad_param.sv
// ============================================================================
// tb_sm3_pad_param : directed vector bench for sm3_pad_param at DW=32 and DW=64
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_sm3_pad_param;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sm3_pad_param_if #(.DW(32)) b32 ();
   sm3_pad_param_if #(.DW(64)) b64 ();

   sm3_pad_param #(.DW(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
   sm3_pad_param #(.DW(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

   logic        sel32;
   logic [63:0] in_d;
   logic [7:0]  in_vb;
   logic        in_vld, in_lst, ena;

   assign b32.msg_inpt_d        = in_d[31:0];
   assign b32.msg_inpt_vld_byte = in_vb[3:0];
   assign b32.msg_inpt_vld      = in_vld & sel32;
   assign b32.msg_inpt_lst      = in_lst;
   assign b32.pad_otpt_ena      = ena;
   assign b64.msg_inpt_d        = in_d;
   assign b64.msg_inpt_vld_byte = in_vb;
   assign b64.msg_inpt_vld      = in_vld & ~sel32;
   assign b64.msg_inpt_lst      = in_lst;
   assign b64.pad_otpt_ena      = ena;

   logic        o_rdy, o_vld, o_lst;
   logic [63:0] o_d;
   assign o_rdy = sel32 ? b32.msg_inpt_rdy : b64.msg_inpt_rdy;
   assign o_vld = sel32 ? b32.pad_otpt_vld : b64.pad_otpt_vld;
   assign o_lst = sel32 ? b32.pad_otpt_lst : b64.pad_otpt_lst;
   assign o_d   = sel32 ? {32'h0, b32.pad_otpt_d} : b64.pad_otpt_d;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          dw;
      int          nbytes;
      bit          rnd_ena;
      bit          junk_vb;
      int          exp_words;
      int          pad_idx;
      logic [63:0] len_lo;
   } vec_t;

   vec_t        vecs[10];
   logic [63:0] exp_q[$];
   logic [63:0] got_q[$];
   logic        got_lst[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] msg_byte(input int i);
      return 8'(32'h61 + i);
   endfunction

   // Byte-level golden padding: message, 0x80, zeros to 56 mod 64, 64-bit length.
   function automatic void build_ref(input int dw, input int nbytes);
      logic [7:0]  b[$];
      logic [63:0] len;
      logic [63:0] x;
      int          nb;
      nb = dw / 8;
      exp_q.delete();
      for (int i = 0; i < nbytes; i++) b.push_back(msg_byte(i));
      b.push_back(8'h80);
      while ((b.size() % 64) != 56) b.push_back(8'h00);
      len = 64'(nbytes) * 64'd8;
      for (int i = 7; i >= 0; i--) b.push_back(len[8*i +: 8]);
      for (int w = 0; w < b.size() / nb; w++) begin
         x = '0;
         for (int j = 0; j < nb; j++) x = (x << 8) | 64'(b[w*nb + j]);
         exp_q.push_back(x);
      end
   endfunction

   task automatic drive(input int dw, input int nbytes, input bit junk, output int acc_cyc);
      int          nb, nw, k, idx;
      logic [63:0] d;
      logic [7:0]  vb;
      logic        s;
      nb = dw / 8;
      nw = (nbytes == 0) ? 1 : (nbytes + nb - 1) / nb;
      acc_cyc = -1;
      for (int w = 0; w < nw; w++) begin
         d = '0;
         for (int j = 0; j < nb; j++) begin
            idx = w * nb + j;
            d = (d << 8) | 64'((idx < nbytes) ? msg_byte(idx) : 8'hEE);
         end
         if (w != nw - 1) begin
            vb = 8'($urandom);
         end else begin
            k  = nbytes - w * nb;
            vb = '0;
            for (int j = 0; j < nb; j++) begin
               if (j < k) vb[nb-1-j] = 1'b1;
               else if (j > k && junk) vb[nb-1-j] = 1'b1;
            end
         end
         in_d = d; in_vb = vb; in_vld = 1'b1; in_lst = (w == nw - 1);
         s = 1'b0;
         for (int c = 0; c < 300 && !s; c++) begin
            @(negedge clk);
            s = o_rdy;
            if (s && w == 0) acc_cyc = cyc;
            @(posedge clk);
            #1;
         end
         if (!s) begin
            chk("input_accept_timeout", 64'd0, 64'd1);
            break;
         end
      end
      in_vld = 1'b0;
      in_lst = 1'b0;
   endtask

   task automatic collect(input bit rnd, output int first_cyc, output int last_cyc);
      bit          stall, done;
      logic [63:0] pd;
      logic        pl;
      stall = 1'b0; done = 1'b0; pd = '0; pl = 1'b0;
      got_q.delete(); got_lst.delete();
      first_cyc = -1; last_cyc = -1;
      for (int c = 0; c < 800 && !done; c++) begin
         ena = rnd ? (($urandom % 3) != 0) : 1'b1;
         @(negedge clk);
         if (stall) begin
            chk("stall_d_stable", o_d, pd);
            chk("stall_lst_stable", 64'(o_lst), 64'(pl));
            chk("stall_vld_stable", 64'(o_vld), 64'd1);
         end
         stall = 1'b0;
         if (o_vld && !ena) begin
            chk("rdy_low_when_stalled", 64'(o_rdy), 64'd0);
            stall = 1'b1; pd = o_d; pl = o_lst;
         end
         if (o_vld && o_lst) chk("rdy_low_at_lst", 64'(o_rdy), 64'd0);
         if (o_vld && ena) begin
            if (first_cyc < 0) first_cyc = cyc;
            got_q.push_back(o_d);
            got_lst.push_back(o_lst);
            if (o_lst) begin
               done = 1'b1;
               last_cyc = cyc;
            end
         end
         @(posedge clk);
         #1;
      end
      if (!done) chk("output_lst_timeout", 64'd0, 64'd1);
      ena = 1'b1;
   endtask

   task automatic run_case(input int i);
      vec_t        v;
      int          acc, f, l, nb, p, n;
      logic [63:0] tmp;
      v  = vecs[i];
      nb = v.dw / 8;
      sel32 = (v.dw == 32);
      build_ref(v.dw, v.nbytes);
      @(posedge clk);
      #1;
      fork
         drive(v.dw, v.nbytes, v.junk_vb, acc);
         collect(v.rnd_ena, f, l);
      join
      n = got_q.size();
      chk($sformatf("v%0d_word_count", i), 64'(n), 64'(v.exp_words));
      for (int w = 0; w < n && w < exp_q.size(); w++) begin
         chk($sformatf("v%0d_word%0d", i, w), got_q[w], exp_q[w]);
         chk($sformatf("v%0d_lst%0d", i, w), 64'(got_lst[w]), 64'(w == n - 1));
      end
      if (n == v.exp_words) begin
         chk($sformatf("v%0d_len_lo", i), got_q[n-1], v.len_lo);
         p   = v.nbytes - v.pad_idx * nb;
         tmp = got_q[v.pad_idx] >> (8 * (nb - 1 - p));
         chk($sformatf("v%0d_pad80_pos", i), 64'(tmp[7:0]), 64'h80);
      end
      if (!v.rnd_ena) begin
         chk($sformatf("v%0d_latency", i), 64'(f), 64'(acc + 1));
         chk($sformatf("v%0d_back_to_back", i), 64'(l - f + 1), 64'(v.exp_words));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32,  3, 1'b0, 1'b0, 16,  0, 64'h18};
      vecs[1] = '{32, 55, 1'b0, 1'b0, 16, 13, 64'h1B8};
      vecs[2] = '{32, 56, 1'b0, 1'b0, 32, 14, 64'h1C0};
      vecs[3] = '{64,  3, 1'b0, 1'b0,  8,  0, 64'h18};
      vecs[4] = '{64,  0, 1'b0, 1'b0,  8,  0, 64'h0};
      vecs[5] = '{32,  3, 1'b1, 1'b0, 16,  0, 64'h18};
      vecs[6] = '{64, 60, 1'b1, 1'b0, 16,  7, 64'h1E0};
      vecs[7] = '{32, 62, 1'b1, 1'b1, 32, 15, 64'h1F0};
      vecs[8] = '{64, 56, 1'b0, 1'b0, 16,  7, 64'h1C0};
      vecs[9] = '{32,  1, 1'b0, 1'b1, 16,  0, 64'h8};

      ena = 1'b1; in_vld = 1'b0; in_lst = 1'b0; in_d = '0; in_vb = '0;
      sel32 = 1'b1; rst_n = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_vld32", 64'(b32.pad_otpt_vld), 64'd0);
      chk("rst_lst32", 64'(b32.pad_otpt_lst), 64'd0);
      chk("rst_d32",   64'(b32.pad_otpt_d),   64'd0);
      chk("rst_rdy32", 64'(b32.msg_inpt_rdy), 64'd0);
      chk("rst_vld64", 64'(b64.pad_otpt_vld), 64'd0);
      chk("rst_d64",   b64.pad_otpt_d,        64'd0);
      chk("rst_rdy64", 64'(b64.msg_inpt_rdy), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rdy_after_rst32", 64'(b32.msg_inpt_rdy), 64'd1);
      chk("rdy_after_rst64", 64'(b64.msg_inpt_rdy), 64'd1);

      for (int i = 0; i < 10; i++) run_case(i);

      // Mid-message reset with a word parked in the output register.
      sel32 = 1'b1;
      @(posedge clk);
      #1;
      ena = 1'b0; in_d = 64'h11223344; in_vb = 8'h0F; in_vld = 1'b1; in_lst = 1'b0;
      @(negedge clk);
      chk("mid_rdy", 64'(o_rdy), 64'd1);
      @(posedge clk);
      #1 in_vld = 1'b0;
      @(negedge clk);
      chk("mid_word_held", 64'(o_vld), 64'd1);
      chk("mid_word_data", o_d, 64'h11223344);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_rdy", 64'(o_rdy), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      ena = 1'b1;
      @(negedge clk);
      chk("mid_rst_vld_clr", 64'(o_vld), 64'd0);
      run_case(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
